// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timer datapath: FSM states,
// default widths and the legacy fixed-speed divisors.
package stopwatch_pkg;

  localparam int unsigned DIV_W_DEF  = 16;
  localparam int unsigned TCNT_W_DEF = 8;

  localparam int unsigned DIV_1X  = 1;
  localparam int unsigned DIV_4X  = 4;
  localparam int unsigned DIV_20X = 20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP
  } sw_state_t;

endpackage

// File: rtl/tick_phase_cnt.sv
// Phase counter for the tick generator: counts 0..limit-1 while enabled,
// holds while disabled, and can restart from zero on clr.
module tick_phase_cnt
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] limit,
  output logic             wrap,
  output logic [DIV_W-1:0] phase
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] base;

  // clr together with en restarts the period: this edge counts from zero
  always_comb begin
    base = clr ? '0 : phase;
    wrap = en && (base == (limit - ONE));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase <= '0;
    end else if (en) begin
      phase <= wrap ? '0 : base + ONE;
    end else begin
      phase <= base;
    end
  end

endmodule

// File: rtl/tick_rate_gen.sv
// Programmable tick-enable generator with pause, single-step, deferred
// glitch-free divisor apply and a free-running tick count.
module tick_rate_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV_W       = DIV_W_DEF,
  parameter int unsigned DEFAULT_DIV = DIV_1X,
  parameter int unsigned TCNT_W      = TCNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run,
  input  logic              step,
  input  logic              sync_clr,
  input  logic [DIV_W-1:0]  div_val,
  input  logic              div_load,
  output logic              tick,
  output logic [TCNT_W-1:0] tick_count,
  output logic [DIV_W-1:0]  div_active,
  output logic              load_pending,
  output logic              load_err,
  output logic              running
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  sw_state_t        state, state_nxt;
  logic [DIV_W-1:0] shadow;
  logic [DIV_W-1:0] limit;
  logic [DIV_W-1:0] phase;
  logic             in_idle, idle_apply, cnt_en, phase_clr, wrap;
  logic             step_go, tick_nxt, apply, load_ok;

  // A pending divisor applied in IDLE starts a fresh period with the new
  // limit on that same edge, so a coincident run edge already counts with it.
  always_comb begin
    in_idle    = (state == ST_IDLE);
    idle_apply = in_idle && load_pending;
    cnt_en     = run && !sync_clr;
    phase_clr  = sync_clr || idle_apply;
    limit      = idle_apply ? shadow : div_active;
    step_go    = in_idle && step && !run;
    tick_nxt   = !sync_clr && (wrap || step_go);
    apply      = load_pending && (sync_clr || in_idle || wrap);
    load_ok    = div_load && (div_val != '0);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (run)       state_nxt = ST_RUN;
        else if (step) state_nxt = ST_STEP;
      end
      ST_RUN:  if (!run) state_nxt = ST_IDLE;
      ST_STEP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  tick_phase_cnt #(
    .DIV_W(DIV_W)
  ) u_phase (
    .clk   (clk),
    .rstn  (rstn),
    .en    (cnt_en),
    .clr   (phase_clr),
    .limit (limit),
    .wrap  (wrap),
    .phase (phase)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      running      <= 1'b0;
      tick         <= 1'b0;
      tick_count   <= '0;
      div_active   <= DEF_DIV;
      shadow       <= DEF_DIV;
      load_pending <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
      tick    <= tick_nxt;
      if (sync_clr)      tick_count <= '0;
      else if (tick_nxt) tick_count <= tick_count + TCNT_W'(1);
      if (apply) begin
        div_active   <= shadow;
        load_pending <= 1'b0;
      end
      // a new request on an apply edge queues behind the one being applied
      if (load_ok) begin
        shadow       <= div_val;
        load_pending <= 1'b1;
      end
      load_err <= div_load && (div_val == '0);
    end
  end

  a_phase_in_range: assert property (@(posedge clk) disable iff (!rstn) phase < div_active);

endmodule

// File: doc/tick_rate_gen.md
# tick_rate_gen

Parametrised tick-enable generator for the stopwatch timer datapath. Produces a single-cycle `tick` every `div_active` clock cycles. Adds four features to the fixed-mode speed controller:
- runtime-programmable divisor with glitch-free deferred apply;
- pause with phase retention;
- single-step while paused;
- a free-running tick count.

The timer core uses `tick` as its increment enable.

## Interface
- `DIV_W`, 16: width of divisor and phase counter.
- `DEFAULT_DIV`, 1: `div_active` value after reset; must be 1..2^DIV_W-1.
- `TCNT_W`, 8: width of `tick_count`.

- `clk`  in  1: clock, rising edge.
- `rstn`  in  1: reset, asynchronous, active-low.
- `run`  in  1: level; 1 = generate ticks, 0 = pause.
- `step`  in  1: pulse; one tick while paused.
- `sync_clr`  in  1: pulse; synchronous clear of phase and `tick_count`.
- `div_val`  in  DIV_W: requested divisor.
- `div_load`  in  1: pulse; request `div_val` be loaded.
- `tick`  out  1: registered single-cycle enable pulse.
- `tick_count`  out  TCNT_W: ticks issued since reset or last clear; wraps modulo 2^TCNT_W.
- `div_active`  out  DIV_W: divisor currently in effect.
- `load_pending`  out  1: shadow divisor waiting to be applied.
- `load_err`  out  1: single-cycle pulse; `div_load` with `div_val`=0 rejected.
- `running`  out  1: FSM in RUN.

## Operation
- **FSM states:** IDLE, RUN, STEP.
  - IDLE → RUN: `run`=1.
  - IDLE → STEP: `step`=1 and `run`=0.
  - STEP → IDLE: unconditional after one cycle.
  - RUN → IDLE: `run`=0.
- **Counting rule.** Applies on every edge where `run`=1, including the IDLE→RUN edge:
  - if `phase` == `div_active`-1: `phase`<=0, `tick`<=1, `tick_count`++;
  - else: `phase`++, `tick`<=0.
- **Pause.** `run`=0 holds `phase`; it is not cleared. Resume continues from the held phase.
- **Step.** Entering STEP issues exactly one tick and increments `tick_count`; `phase` is unchanged. `step` is ignored in RUN, in STEP, and when `run`=1.
- **Divisor load.**
  - `div_load` with `div_val`≠0 writes the shadow register and sets `load_pending`.
  - A second load while pending overwrites the shadow; the latest value wins.
  - `div_val`=0 leaves shadow and `load_pending` unchanged and pulses `load_err`.
- **Divisor apply.** The shadow is copied to `div_active` and `load_pending` clears at the first of:
  - a phase wrap in RUN, which is the same edge as the tick;
  - any edge in IDLE, with `phase`<=0;
  - a `sync_clr` edge.
  
  Apply never occurs mid-period, so no short or long period is produced.
- **`sync_clr`.** Highest priority below reset. It forces:
  - `phase`<=0;
  - `tick`<=0; a coincident wrap tick is suppressed and not counted;
  - `tick_count`<=0.
  
  The FSM state is unchanged. A pending load is applied.
- **Simultaneous `div_load` and apply edge.** The old shadow is applied and the new request becomes pending.

## Timing
- **Reset values:** `tick`=0, `tick_count`=0, `div_active`=`DEFAULT_DIV`, `load_pending`=0, `load_err`=0, `running`=0; state IDLE; `phase`=0; shadow=`DEFAULT_DIV`.
- **First tick.** With divisor N and `run` rising before edge k, the first tick is high in the cycle after edge k+N-1. After that, ticks occur every N cycles.
- **Divisor 1.** N=1 gives `tick` high every cycle while `run`=1.
- **Step latency.** `tick` is high exactly one cycle, beginning the cycle after the edge that samples `step`.
- **Reset mid-operation.** Asynchronous reset mid-operation returns all registers to their reset values immediately. No tick is issued on reset release.
- **Pulse widths.** `load_err` is high for one cycle, following the edge that samples the bad request.
- **Wrap.** `tick_count` wraps from 2^TCNT_W-1 to 0 with no flag.

## Structure
- **Shared package `stopwatch_pkg`:**
  - FSM state encodings `ST_IDLE`, `ST_RUN`, `ST_STEP`;
  - `DIV_W`/`TCNT_W` defaults;
  - named divisor constants for the legacy speeds: `DIV_1X`=1, `DIV_4X`=4, `DIV_20X`=20.
- **Sub-module `tick_phase_cnt`:**
  - holds the phase counter with hold/clear/wrap;
  - inputs: `en`, `clr`, `limit`;
  - outputs: `wrap`, `phase`.
  
  FSM, shadow and `tick_count` logic stay in `tick_rate_gen`.

## Test plan
- **Reset defaults.** Reset, then `run`=1 with `DEFAULT_DIV`=1 → `tick` high every cycle from the cycle after the first `run` edge; `tick_count` counts 1, 2, 3, ….
- **Pause and resume.** Load 4, hold `run` 10 cycles → ticks after edges 4 and 8. Drop `run` for 5 cycles, then resume → next tick 2 run-edges later, since `phase` was held at 2.
- **Deferred load.** Running at N=20, `div_load` 3 at phase 5 → `load_pending`=1 until the 20th edge. The next periods are 3 cycles, with no intermediate short period.
- **Zero divisor.** `div_load` with 0 → `load_err` pulse of one cycle; `div_active` and `load_pending` unchanged.
- **Step.** Paused, `step` pulse → one tick and `tick_count`+1. `step` while `run`=1 → no extra tick.
- **Clear.** `sync_clr` coincident with a wrap edge and a pending load of 7 → no tick, `tick_count`=0, `div_active`=7. The next tick comes 7 edges later. Also `tick_count` wrap from 255 to 0 with `TCNT_W`=8.
